mul_op_sequencer: RTL
=====================

// Module: mul_op_sequencer
// PURPOSE
//  Upstream/downstream controller for the ALU's 8-bit shift-add multiplier.
//  Accepts a signed operand pair on a valid/ready handshake and latches it.
//  Clears the multiplier, drives it until it reports completion, then captures the
//  16-bit product. Presents the product on a valid/ready output with a timeout error.
// PARAMETERS
//  W           8   operand width (product is 2*W); only 8 is supported
//  TIMEOUT_CYC 40  max cycles in RUN before err is raised (multiplier needs 2*W+1)
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  res_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair offered
//  in_ready   out  1   high only in IDLE
//  in_x       in   8   multiplicand (signed)
//  in_y       in   8   multiplier operand (signed)
//  m_x        out  8   to multiplier x (latched in_x)
//  m_y        out  8   to multiplier y (latched in_y)
//  m_not_y    out  8   to multiplier not_y; always bitwise ~m_y
//  m_en       out  1   multiplier enable
//  m_res      out  1   multiplier sync clear, active-high
//  m_prod     in   16  multiplier product
//  m_comp     in   1   multiplier done flag; sticky until m_res
//  out_valid  out  1   product available
//  out_ready  in   1   consumer accepts product
//  out_prod   out  16  captured signed product
//  out_err    out  1   qualified by out_valid; timeout occurred, out_prod=0
// BEHAVIOUR
//  Reset (res_n=0, async): state=IDLE, m_x=m_y=0, m_not_y=8'hFF, m_en=0, m_res=1,
//   out_valid=0, out_prod=0, out_err=0, timeout counter=0.
//  FSM: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1, m_res=1, m_en=0. in_valid&in_ready latches in_x/in_y, goes to CLEAR.
//  CLEAR: 1 cycle; m_res=1 with new operands stable, so the multiplier starts clean.
//  RUN: m_res=0, m_en=1; counter increments each cycle.
//   m_comp=1: capture out_prod=m_prod, out_err=0, go DONE.
//   counter==TIMEOUT_CYC-1 without m_comp: out_prod=0, out_err=1, go DONE.
//   m_comp wins if it coincides with the final count.
//  DONE: out_valid=1, m_en=0, m_res=0; out_prod/out_err stable until out_ready.
//   out_valid&out_ready: return to IDLE, clear counter.
//   in_ready stays 0 in DONE, so no new operand is accepted until the product is consumed.
//  Latency: accept edge -> out_valid = 1 (CLEAR) + RUN cycles + 1; nominal 2*W+3.
//  Products are two's complement: -128*-128 = 16'h4000; no saturation.
//  in_x/in_y are ignored outside IDLE.
//  Reset asserted mid-RUN or mid-DONE aborts the operation; the pending product is lost.
// CONFIGURATION
//  MUL_OVF_FLAG_EN defined: adds output out_ovf (1 bit, reset 0, qualified by out_valid).
//   out_ovf=1 when the captured product does not fit signed 8 bits,
//   i.e. out_prod[15:7] is neither all-0 nor all-1. Forced 0 on timeout.
//  Not defined: port and logic absent; all other behaviour unchanged.
// STRUCTURE
//  Package alu_pkg: FSM state typedef (IDLE/CLEAR/RUN/DONE, 2-bit encoding),
//   MUL_W=8, MUL_PROD_W=16.
//  Sub-module mul_timeout_ctr: counter with clear, enable and terminal-count output
//   at TIMEOUT_CYC-1.
//  The FSM and output registers stay in mul_op_sequencer.
//  The testbench instantiates the real multiplier plus a stub for m_comp fault injection.
// TESTING
//  x=7, y=5, out_ready=1 -> out_prod=16'h0023, out_err=0, out_valid 2*W+3 cycles after accept.
//  x=-3 (8'hFD), y=4 -> out_prod=16'hFFF4; with MUL_OVF_FLAG_EN, out_ovf=0.
//  x=-128, y=-128 -> out_prod=16'h4000; with MUL_OVF_FLAG_EN, out_ovf=1.
//  out_ready held 0 for 10 cycles -> out_valid, out_prod stable; in_ready=0; then one handshake -> IDLE.
//  Stub m_comp stuck 0 -> out_valid with out_err=1, out_prod=0 after TIMEOUT_CYC RUN cycles.
//  res_n pulsed low mid-RUN -> all outputs at reset values immediately; next op 6*7 -> 16'h002A.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM state encoding for the ALU multiplier sequencer.
package alu_pkg;

  localparam int MUL_W      = 8;
  localparam int MUL_PROD_W = 16;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t ST_IDLE  = 2'd0;
  localparam mul_state_t ST_CLEAR = 2'd1;
  localparam mul_state_t ST_RUN   = 2'd2;
  localparam mul_state_t ST_DONE  = 2'd3;

  // True when a product is representable as a signed 8-bit value.
  function automatic logic fits_s8(input logic [MUL_PROD_W-1:0] p);
    return (p[MUL_PROD_W-1:MUL_W-1] == '0) || (p[MUL_PROD_W-1:MUL_W-1] == '1);
  endfunction

endpackage

// File: rtl/mul_timeout_ctr.sv
// RUN-phase cycle counter; flags the last permitted cycle before a timeout.
module mul_timeout_ctr #(
  parameter int TIMEOUT_CYC = 40,
  parameter int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic clk,
  input  logic res_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count_reg;

  assign tc = (count_reg == CW'(TIMEOUT_CYC - 1));

  // Holds at the terminal value so it can never wrap back to zero.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mul_op_sequencer.sv
// Handshake front-end for the 8-bit shift-add multiplier with timeout detection.
// Optional macro MUL_OVF_FLAG_EN adds the out_ovf signed-8-bit overflow flag.
module mul_op_sequencer
  import alu_pkg::*;
#(
  parameter int W           = MUL_W,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic           clk,
  input  logic           res_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic [W-1:0]   m_x,
  output logic [W-1:0]   m_y,
  output logic [W-1:0]   m_not_y,
  output logic           m_en,
  output logic           m_res,
  input  logic [2*W-1:0] m_prod,
  input  logic           m_comp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic           out_err
`ifdef MUL_OVF_FLAG_EN
  ,
  output logic           out_ovf
`endif
);

  mul_state_t     state_reg;
  mul_state_t     state_next;
  logic [W-1:0]   x_reg;
  logic [W-1:0]   y_reg;
  logic [2*W-1:0] prod_reg;
  logic           err_reg;
  logic           timeout_tc;

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign m_en      = (state_reg == ST_RUN);
  // Clear is held through IDLE and CLEAR so the multiplier starts from a known state.
  assign m_res     = (state_reg == ST_IDLE) || (state_reg == ST_CLEAR);
  assign m_x       = x_reg;
  assign m_y       = y_reg;
  assign m_not_y   = ~y_reg;
  assign out_prod  = prod_reg;
  assign out_err   = err_reg;

  mul_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk   (clk),
    .res_n (res_n),
    .clr   (state_reg != ST_RUN),
    .en    (state_reg == ST_RUN),
    .tc    (timeout_tc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_RUN;
      ST_RUN:   if (m_comp || timeout_tc) state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg <= ST_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      prod_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) && in_valid) begin
        x_reg <= in_x;
        y_reg <= in_y;
      end
      // Completion takes priority over a timeout landing on the same cycle.
      if (state_reg == ST_RUN) begin
        if (m_comp) begin
          prod_reg <= m_prod;
          err_reg  <= 1'b0;
        end else if (timeout_tc) begin
          prod_reg <= '0;
          err_reg  <= 1'b1;
        end
      end
    end
  end

`ifdef MUL_OVF_FLAG_EN
  logic ovf_reg;

  assign out_ovf = ovf_reg;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (m_comp) begin
        ovf_reg <= !fits_s8(m_prod);
      end else if (timeout_tc) begin
        ovf_reg <= 1'b0;
      end
    end
  end
`endif

endmodule
